// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// pll_reconfig_seq: Avalon-MM sequencer that reprograms the pll_cfg dividers,
// pulses the PLL reset, waits for lock and applies a phase step relative to the base phase.
module pll_reconfig_seq #(
  parameter int GAP_CYCLES   = 7,
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_TIMEOUT = 5000000,
  parameter int PH_CNT_SEL   = 0
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic        start,
  input  logic [31:0] cfg_m,
  input  logic [31:0] cfg_k,
  input  logic [31:0] cfg_c,
  input  logic [15:0] tgt_phase,
  input  logic [15:0] base_phase,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        pll_reset,
  output logic        busy,
  output logic        done,
  output logic        lock_err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RST_LOAD  = RW'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LOCK_LOAD = LW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [4:0]    PH_SEL    = 5'(PH_CNT_SEL);
  localparam logic [3:0]    LAST_MAIN = 4'd8;
  localparam logic [3:0]    LAST_PH   = 4'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    GAP   = 3'd2,
    PRST  = 3'd3,
    LOCKW = 3'd4,
    PHASE = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      idx, idx_nxt;
  logic            ph_mode, ph_mode_nxt;
  logic            wr_act, wr_act_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [RW-1:0]   rst_cnt, rst_nxt;
  logic [LW-1:0]   lock_cnt, lock_nxt;
  logic            err_nxt;
  logic            advance;

  logic [31:0]     lat_m;
  logic [31:0]     lat_k;
  logic [31:0]     lat_c;
  logic [15:0]     lat_tgt;
  logic [15:0]     lat_base;

  logic            ph_up;
  logic [15:0]     ph_diff;
  logic [31:0]     ph_word;
  logic [5:0]      ent_addr;
  logic [31:0]     ent_data;

  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state    <= IDLE;
      idx      <= '0;
      ph_mode  <= 1'b0;
      wr_act   <= 1'b0;
      gap_cnt  <= '0;
      rst_cnt  <= '0;
      lock_cnt <= '0;
      lock_err <= 1'b0;
      lat_m    <= '0;
      lat_k    <= '0;
      lat_c    <= '0;
      lat_tgt  <= '0;
      lat_base <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      ph_mode  <= ph_mode_nxt;
      wr_act   <= wr_act_nxt;
      gap_cnt  <= gap_nxt;
      rst_cnt  <= rst_nxt;
      lock_cnt <= lock_nxt;
      lock_err <= err_nxt;
      if ((state == IDLE) && start) begin
        lat_m    <= cfg_m;
        lat_k    <= cfg_k;
        lat_c    <= cfg_c;
        lat_tgt  <= tgt_phase;
        lat_base <= base_phase;
      end
    end
  end

  // Phase word: magnitude in [15:0], counter select in [20:16], up/down in bit 21.
  always_comb begin
    ph_up   = lat_tgt > lat_base;
    ph_diff = ph_up ? (lat_tgt - lat_base) : (lat_base - lat_tgt);
    ph_word = {10'd0, ph_up, PH_SEL, ph_diff};
  end

  always_comb begin
    ent_addr = '0;
    ent_data = '0;
    if (!ph_mode) begin
      case (idx)
        4'd0: begin ent_addr = 6'd0; ent_data = 32'd0;                 end
        4'd1: begin ent_addr = 6'd4; ent_data = lat_m;                 end
        4'd2: begin ent_addr = 6'd7; ent_data = lat_k;                 end
        4'd3: begin ent_addr = 6'd3; ent_data = 32'h0001_0000;         end
        4'd4: begin ent_addr = 6'd5; ent_data = lat_c;                 end
        4'd5: begin ent_addr = 6'd5; ent_data = lat_c | 32'h0004_0000; end
        4'd6: begin ent_addr = 6'd9; ent_data = 32'd1;                 end
        4'd7: begin ent_addr = 6'd8; ent_data = 32'd7;                 end
        4'd8: begin ent_addr = 6'd2; ent_data = 32'd0;                 end
        default: ;
      endcase
    end else begin
      case (idx)
        4'd0: begin ent_addr = 6'd0; ent_data = 32'd0;   end
        4'd1: begin ent_addr = 6'd6; ent_data = ph_word; end
        4'd2: begin ent_addr = 6'd2; ent_data = 32'd0;   end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    ph_mode_nxt = ph_mode;
    wr_act_nxt  = wr_act;
    gap_nxt     = gap_cnt;
    rst_nxt     = rst_cnt;
    lock_nxt    = lock_cnt;
    err_nxt     = lock_err;
    advance     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = WR;
          idx_nxt     = '0;
          ph_mode_nxt = 1'b0;
          wr_act_nxt  = pll_locked;
          lock_nxt    = LOCK_LOAD;
          err_nxt     = 1'b0;
        end
      end
      WR: begin
        // Once a write is on the bus it is held until accepted, regardless of lock.
        if (wr_act) begin
          if (!mgmt_waitrequest) begin
            wr_act_nxt = 1'b0;
            if (GAP_CYCLES > 0) begin
              state_nxt = GAP;
              gap_nxt   = GAP_LOAD;
            end else begin
              advance = 1'b1;
            end
          end
        end else if (pll_locked) begin
          wr_act_nxt = 1'b1;
        end else if (lock_cnt == '0) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          lock_nxt = lock_cnt - LW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          advance = 1'b1;
        end else begin
          gap_nxt = gap_cnt - GW'(1);
        end
      end
      PRST: begin
        if (rst_cnt == '0) begin
          state_nxt = LOCKW;
          lock_nxt  = LOCK_LOAD;
        end else begin
          rst_nxt = rst_cnt - RW'(1);
        end
      end
      LOCKW: begin
        if (pll_locked) begin
          state_nxt = PHASE;
        end else if (lock_cnt == '0) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          lock_nxt = lock_cnt - LW'(1);
        end
      end
      PHASE: begin
        if (lat_tgt == lat_base) begin
          state_nxt = DONE;
        end else begin
          state_nxt   = WR;
          idx_nxt     = '0;
          ph_mode_nxt = 1'b1;
          wr_act_nxt  = pll_locked;
          lock_nxt    = LOCK_LOAD;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (advance) begin
      if (!ph_mode && (idx == LAST_MAIN)) begin
        state_nxt = PRST;
        rst_nxt   = RST_LOAD;
      end else if (ph_mode && (idx == LAST_PH)) begin
        state_nxt = DONE;
      end else begin
        state_nxt  = WR;
        idx_nxt    = idx + 4'd1;
        wr_act_nxt = pll_locked;
        lock_nxt   = LOCK_LOAD;
      end
    end

    mgmt_write     = (state == WR) && wr_act;
    mgmt_address   = mgmt_write ? ent_addr : '0;
    mgmt_writedata = mgmt_write ? ent_data : '0;
    pll_reset      = (state == PRST);
    busy           = (state != IDLE) && (state != DONE);
    done           = (state == DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
// Bench for pll_reconfig_seq: expected Avalon writes are queued at each start and
// compared as the DUT issues them; directed steps cover reset, phase, stall, timeout.
module tb_pll_reconfig_seq;

  localparam int TB_LOCK_TIMEOUT = 100;

  logic        CLK_50M = 1'b0;
  logic        RESET;
  logic        start;
  logic [31:0] cfg_m;
  logic [31:0] cfg_k;
  logic [31:0] cfg_c;
  logic [15:0] tgt_phase;
  logic [15:0] base_phase;
  logic        pll_locked = 1'b1;
  logic        mgmt_waitrequest = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        pll_reset;
  logic        busy;
  logic        done;
  logic        lock_err;

  pll_reconfig_seq #(
    .GAP_CYCLES   (7),
    .RST_CYCLES   (8),
    .LOCK_TIMEOUT (TB_LOCK_TIMEOUT),
    .PH_CNT_SEL   (0)
  ) dut (
    .CLK_50M          (CLK_50M),
    .RESET            (RESET),
    .start            (start),
    .cfg_m            (cfg_m),
    .cfg_k            (cfg_k),
    .cfg_c            (cfg_c),
    .tgt_phase        (tgt_phase),
    .base_phase       (base_phase),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .pll_reset        (pll_reset),
    .busy             (busy),
    .done             (done),
    .lock_err         (lock_err)
  );

  always #10 CLK_50M = ~CLK_50M;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_count = 0;
  int hi_cycles = 0;
  int stall_idx = -1;
  int stall_left = 0;
  int stall_hi = 0;
  int prst_len = 0;
  bit prst_prev = 1'b0;
  bit chk_prst = 1'b1;
  int fall_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit done_err = 1'b0;
  int start_cyc = 0;
  int lock_mode = 0;
  int relock = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK_50M) cyc++;

  // Avalon slave, scoreboard compare, pll_reset/done observation and PLL lock model.
  always @(negedge CLK_50M) begin
    if (mgmt_write && (wr_count == stall_idx) && (stall_left > 0)) begin
      mgmt_waitrequest = 1'b1;
      stall_left--;
    end else begin
      mgmt_waitrequest = 1'b0;
    end

    if (mgmt_write) begin
      hi_cycles++;
      check("wr_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        check("wr_addr", 64'(mgmt_address), 64'(exp_q[0].addr));
        check("wr_data", 64'(mgmt_writedata), 64'(exp_q[0].data));
      end
      if (!mgmt_waitrequest) begin
        if (wr_count == stall_idx) stall_hi = hi_cycles;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        wr_count++;
        hi_cycles = 0;
      end
    end

    if (pll_reset) begin
      prst_len++;
    end else if (prst_prev) begin
      if (chk_prst) check("prst_width", 64'(prst_len), 64'(8));
      prst_len = 0;
      fall_cyc = cyc;
    end
    prst_prev = pll_reset;

    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = lock_err;
      check("done_busy", 64'(busy), 64'(0));
    end

    if (pll_reset) begin
      pll_locked = 1'b0;
      relock     = 20;
    end else if (lock_mode == 0) begin
      if (relock > 0) begin
        relock--;
        if (relock == 0) pll_locked = 1'b1;
      end else begin
        pll_locked = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge CLK_50M);
    #1;
  endtask

  task automatic push1(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c,
                          input logic [15:0] t, input logic [15:0] b, input bit with_phase);
    logic [31:0] w;
    push1(6'd0, 32'd0);
    push1(6'd4, m);
    push1(6'd7, k);
    push1(6'd3, 32'h0001_0000);
    push1(6'd5, c);
    push1(6'd5, c | 32'h0004_0000);
    push1(6'd9, 32'd1);
    push1(6'd8, 32'd7);
    push1(6'd2, 32'd0);
    if (with_phase && (t != b)) begin
      if (t > b) w = {16'h0020, t - b};
      else       w = {16'h0000, b - t};
      push1(6'd0, 32'd0);
      push1(6'd6, w);
      push1(6'd2, 32'd0);
    end
    cfg_m      = m;
    cfg_k      = k;
    cfg_c      = c;
    tgt_phase  = t;
    base_phase = b;
    start      = 1'b1;
    start_cyc  = cyc;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0;
    int i;
    n0 = done_cnt;
    i  = 0;
    while ((done_cnt == n0) && (i < budget)) begin
      tick();
      i++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != n0), 64'(1));
    tick();
    tick();
    check({tag, "_done_once"}, 64'(done_cnt - n0), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_wr;
    int n0;
    int i;

    RESET      = 1'b1;
    start      = 1'b0;
    cfg_m      = '0;
    cfg_k      = '0;
    cfg_c      = '0;
    tgt_phase  = '0;
    base_phase = '0;
    repeat (3) tick();
    check("reset_outs", 64'({mgmt_write, mgmt_address, mgmt_writedata, pll_reset, busy, done, lock_err}), 64'(0));
    RESET = 1'b0;
    tick();
    check("idle_outs", 64'({mgmt_write, mgmt_address, mgmt_writedata, pll_reset, busy, done, lock_err}), 64'(0));

    // Basic sequence, equal phase
    base_wr = wr_count;
    do_start(32'h808, 32'hB333_32DD, 32'h2_0302, 16'd29, 16'd29, 1'b1);
    check("basic_busy", 64'(busy), 64'(1));
    wait_done("basic", 400);
    check("basic_latency", 64'(done_cyc - start_cyc), 64'(102));
    check("basic_wr_count", 64'(wr_count - base_wr), 64'(9));
    check("basic_q_empty", 64'(exp_q.size()), 64'(0));
    check("basic_lock_err", 64'(done_err), 64'(0));
    repeat (4) tick();

    // Positive phase step
    base_wr = wr_count;
    do_start(32'h808, 32'hB333_32DD, 32'h2_0302, 16'd30, 16'd29, 1'b1);
    wait_done("pos", 500);
    check("pos_wr_count", 64'(wr_count - base_wr), 64'(12));
    check("pos_q_empty", 64'(exp_q.size()), 64'(0));
    repeat (4) tick();

    // Negative phase step
    base_wr = wr_count;
    do_start(32'h606, 32'h1234_5678, 32'h1_0101, 16'd22, 16'd29, 1'b1);
    wait_done("neg", 500);
    check("neg_wr_count", 64'(wr_count - base_wr), 64'(12));
    check("neg_q_empty", 64'(exp_q.size()), 64'(0));
    repeat (4) tick();

    // Waitrequest stall of 5 cycles on write 3
    base_wr    = wr_count;
    stall_idx  = wr_count + 3;
    stall_left = 5;
    do_start(32'h808, 32'hB333_32DD, 32'h2_0302, 16'd29, 16'd29, 1'b1);
    wait_done("stall", 500);
    check("stall_write_high", 64'(stall_hi), 64'(6));
    check("stall_wr_count", 64'(wr_count - base_wr), 64'(9));
    check("stall_q_empty", 64'(exp_q.size()), 64'(0));
    stall_idx = -1;
    repeat (4) tick();

    // Lock never returns after PLL reset
    lock_mode = 1;
    base_wr   = wr_count;
    do_start(32'h808, 32'hB333_32DD, 32'h2_0302, 16'd30, 16'd29, 1'b0);
    wait_done("tmo", 500);
    check("tmo_done_delay", 64'(done_cyc - fall_cyc), 64'(TB_LOCK_TIMEOUT));
    check("tmo_err_at_done", 64'(done_err), 64'(1));
    check("tmo_wr_count", 64'(wr_count - base_wr), 64'(9));
    check("tmo_q_empty", 64'(exp_q.size()), 64'(0));
    repeat (3) tick();
    check("tmo_err_sticky", 64'(lock_err), 64'(1));
    lock_mode = 0;
    do_start(32'h808, 32'hB333_32DD, 32'h2_0302, 16'd29, 16'd29, 1'b1);
    check("restart_err_clear", 64'(lock_err), 64'(0));
    check("restart_busy", 64'(busy), 64'(1));
    wait_done("restart", 500);
    check("restart_err_done", 64'(done_err), 64'(0));
    check("restart_q_empty", 64'(exp_q.size()), 64'(0));
    repeat (4) tick();

    // Start while busy is ignored, then RESET during PRST
    base_wr = wr_count;
    n0      = done_cnt;
    do_start(32'h808, 32'hB333_32DD, 32'h2_0302, 16'd29, 16'd29, 1'b1);
    i = 0;
    while ((wr_count < base_wr + 3) && (i < 200)) begin
      tick();
      i++;
    end
    check("busy_reach_wr3", 64'(wr_count >= base_wr + 3), 64'(1));
    cfg_m     = 32'hDEAD_BEEF;
    cfg_k     = 32'h0BAD_F00D;
    cfg_c     = 32'h0000_0FFF;
    tgt_phase = 16'd40;
    start     = 1'b1;
    tick();
    start = 1'b0;
    i = 0;
    while (!pll_reset && (i < 200)) begin
      tick();
      i++;
    end
    check("busy_reach_prst", 64'(pll_reset), 64'(1));
    check("busy_wr_count", 64'(wr_count - base_wr), 64'(9));
    repeat (3) tick();
    chk_prst = 1'b0;
    RESET    = 1'b1;
    tick();
    RESET = 1'b0;
    check("midreset_outs", 64'({mgmt_write, mgmt_address, mgmt_writedata, pll_reset, busy, done, lock_err}), 64'(0));
    repeat (20) tick();
    check("midreset_idle", 64'({busy, mgmt_write, pll_reset}), 64'(0));
    check("midreset_wr_count", 64'(wr_count - base_wr), 64'(9));
    check("midreset_no_done", 64'(done_cnt - n0), 64'(0));
    check("midreset_q_empty", 64'(exp_q.size()), 64'(0));
    chk_prst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
